// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port byte memory between the fetch port and the
// load/store port. Each grant walks IDLE -> ACCESS -> RESPOND, giving a fixed two-cycle latency.
module mem_port_arbiter #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        IReq,
    input  logic [31:0] IAddr,
    output logic [31:0] IData,
    output logic        IValid,
    output logic        IErr,
    input  logic        DReq,
    input  logic        DWe,
    input  logic [31:0] DAddr,
    input  logic [31:0] DWData,
    output logic [31:0] DRData,
    output logic        DValid,
    output logic        DErr,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWriteData,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] MemData
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

    state_t      state;
    logic        last_data;
    logic        gnt_data;
    logic        gnt_we;
    logic        gnt_err;
    logic [31:0] gnt_addr;
    logic [31:0] gnt_wdata;

    logic        sel_data;
    logic [31:0] sel_addr;

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a > LAST_WORD);
    endfunction

    // On a tie the port that was not served last wins; last_data resets to fetch.
    always_comb begin
        sel_data = DReq && (!IReq || !last_data);
        sel_addr = sel_data ? DAddr : IAddr;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            last_data    <= 1'b0;
            gnt_data     <= 1'b0;
            gnt_we       <= 1'b0;
            gnt_err      <= 1'b0;
            gnt_addr     <= '0;
            gnt_wdata    <= '0;
            IData        <= '0;
            DRData       <= '0;
            IValid       <= 1'b0;
            IErr         <= 1'b0;
            DValid       <= 1'b0;
            DErr         <= 1'b0;
            MemAddr      <= '0;
            MemWriteData <= '0;
            MemRead      <= 1'b0;
            MemWrite     <= 1'b0;
        end else begin
            IValid   <= 1'b0;
            IErr     <= 1'b0;
            DValid   <= 1'b0;
            DErr     <= 1'b0;
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (IReq || DReq) begin
                        gnt_data  <= sel_data;
                        gnt_we    <= sel_data && DWe;
                        gnt_addr  <= sel_addr;
                        gnt_wdata <= DWData;
                        gnt_err   <= addr_bad(sel_addr);
                        last_data <= sel_data;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Rejected accesses still take this slot but raise no strobe.
                    MemAddr <= gnt_addr;
                    if (!gnt_err) begin
                        if (gnt_we) begin
                            MemWrite     <= 1'b1;
                            MemWriteData <= gnt_wdata;
                        end else begin
                            MemRead <= 1'b1;
                        end
                    end
                    state <= RESPOND;
                end
                RESPOND: begin
                    if (gnt_data) begin
                        DValid <= 1'b1;
                        DErr   <= gnt_err;
                        if (!gnt_err && !gnt_we) DRData <= MemData;
                    end else begin
                        IValid <= 1'b1;
                        IErr   <= gnt_err;
                        if (!gnt_err) IData <= MemData;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a big-endian 1 KiB byte memory model.
module tb_mem_port_arbiter;

    logic        Clk;
    logic        Reset_n;
    logic        IReq;
    logic [31:0] IAddr;
    logic [31:0] IData;
    logic        IValid;
    logic        IErr;
    logic        DReq;
    logic        DWe;
    logic [31:0] DAddr;
    logic [31:0] DWData;
    logic [31:0] DRData;
    logic        DValid;
    logic        DErr;
    logic [31:0] MemAddr;
    logic [31:0] MemWriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] MemData;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_i = '0;
    logic [31:0] exp_d = '0;

    logic [7:0] mem [0:1023];

    mem_port_arbiter #(.MEM_BYTES(1024)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .IReq(IReq), .IAddr(IAddr), .IData(IData), .IValid(IValid), .IErr(IErr),
        .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData), .DRData(DRData),
        .DValid(DValid), .DErr(DErr),
        .MemAddr(MemAddr), .MemWriteData(MemWriteData), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemData(MemData)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [9:0] b0, b1, b2, b3;
    always_comb begin
        b0 = MemAddr[9:0];
        b1 = b0 + 10'd1;
        b2 = b0 + 10'd2;
        b3 = b0 + 10'd3;
        MemData = {mem[b0], mem[b1], mem[b2], mem[b3]};
    end

    always @(posedge Clk) begin
        if (MemWrite) begin
            mem[b0] <= MemWriteData[31:24];
            mem[b1] <= MemWriteData[23:16];
            mem[b2] <= MemWriteData[15:8];
            mem[b3] <= MemWriteData[7:0];
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One complete transaction on a single port, checked cycle by cycle.
    task automatic access(input string tag, input logic is_d, input logic we,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic err, input logic [31:0] rd);
        logic we_eff;
        we_eff = is_d && we;
        if (is_d) begin
            DReq = 1'b1; DWe = we; DAddr = addr; DWData = wd;
        end else begin
            IReq = 1'b1; IAddr = addr;
        end
        step();
        chk({tag, "_grant"}, {28'd0, MemRead, MemWrite, IValid, DValid}, 32'd0);
        step();
        chk({tag, "_strobe"}, {30'd0, MemRead, MemWrite}, {30'd0, !err && !we_eff, !err && we_eff});
        chk({tag, "_novalid"}, {30'd0, IValid, DValid}, 32'd0);
        if (!err) chk({tag, "_addr"}, MemAddr, addr);
        if (!err && we_eff) chk({tag, "_wdata"}, MemWriteData, wd);
        step();
        chk({tag, "_strobe_off"}, {30'd0, MemRead, MemWrite}, 32'd0);
        chk({tag, "_valid"}, {28'd0, IValid, IErr, DValid, DErr},
            {28'd0, !is_d, !is_d && err, is_d, is_d && err});
        if (!err && !we_eff) begin
            if (is_d) exp_d = rd;
            else      exp_i = rd;
        end
        chk({tag, "_idata"}, IData, exp_i);
        chk({tag, "_drdata"}, DRData, exp_d);
        IReq = 1'b0;
        DReq = 1'b0;
        step();
        chk({tag, "_valid_off"}, {30'd0, IValid, DValid}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[0] = 8'h18; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h64;
        mem[4] = 8'hA1; mem[5] = 8'hB2; mem[6] = 8'hC3; mem[7] = 8'hD4;
        Reset_n = 1'b0;
        IReq = 1'b0; IAddr = '0;
        DReq = 1'b0; DWe = 1'b0; DAddr = '0; DWData = '0;
        step();
        step();
        chk("rst_idata", IData, 32'd0);
        chk("rst_drdata", DRData, 32'd0);
        chk("rst_memaddr", MemAddr, 32'd0);
        chk("rst_memwdata", MemWriteData, 32'd0);
        chk("rst_flags", {26'd0, IValid, IErr, DValid, DErr, MemRead, MemWrite}, 32'd0);
        Reset_n = 1'b1;
        step();

        access("fetch0", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'h18000064);
        access("store8", 1'b1, 1'b1, 32'd8, 32'hDEADBEEF, 1'b0, 32'd0);
        chk("mem8", {24'd0, mem[8]}, 32'h000000DE);
        access("load8", 1'b1, 1'b0, 32'd8, 32'd0, 1'b0, 32'hDEADBEEF);
        access("load6_err", 1'b1, 1'b0, 32'd6, 32'd0, 1'b1, 32'd0);
        access("fetch1024_err", 1'b0, 1'b0, 32'd1024, 32'd0, 1'b1, 32'd0);
        access("store1020", 1'b1, 1'b1, 32'd1020, 32'h12345678, 1'b0, 32'd0);
        access("load1020", 1'b1, 1'b0, 32'd1020, 32'd0, 1'b0, 32'h12345678);
        access("fetch1020", 1'b0, 1'b0, 32'd1020, 32'd0, 1'b0, 32'h12345678);

        // Reset while a store strobe is high: everything drops at once and no completion follows.
        DReq = 1'b1; DWe = 1'b1; DAddr = 32'd16; DWData = 32'hCAFEF00D;
        step();
        step();
        chk("rst_mid_write", {31'd0, MemWrite}, 32'd1);
        #1 Reset_n = 1'b0;
        #1;
        chk("rst_mid_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
        chk("rst_mid_valids", {28'd0, IValid, IErr, DValid, DErr}, 32'd0);
        chk("rst_mid_drdata", DRData, 32'd0);
        #1 Reset_n = 1'b1;
        DReq = 1'b0; DWe = 1'b0;
        exp_i = '0;
        exp_d = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_mid_no_dvalid", {31'd0, DValid}, 32'd0);
        end

        // Both ports held: data wins first tie after reset, then grants alternate.
        IReq = 1'b1; IAddr = 32'd0;
        DReq = 1'b1; DWe = 1'b0; DAddr = 32'd4;
        for (int k = 0; k < 12; k++) begin
            step();
            chk($sformatf("tie_k%0d_valid", k), {30'd0, DValid, IValid},
                {30'd0, (k % 6) == 2, (k % 6) == 5});
            chk($sformatf("tie_k%0d_read", k), {31'd0, MemRead}, {31'd0, (k % 3) == 1});
            if ((k % 3) == 1)
                chk($sformatf("tie_k%0d_addr", k), MemAddr, ((k % 6) == 1) ? 32'd4 : 32'd0);
            if ((k % 6) == 2) chk("tie_drdata", DRData, 32'hA1B2C3D4);
            if ((k % 6) == 5) chk("tie_idata", IData, 32'h18000064);
        end
        IReq = 1'b0;
        DReq = 1'b0;
        step();
        step();
        chk("final_idle", {28'd0, IValid, DValid, MemRead, MemWrite}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
